// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if
// Register bus between the embedded microcontroller and the quadrature
// decoder.
//   rden : read enable; dout reads 0 when low
//   wren : write strobe, sampled on the rising clock edge
//   addr : register address (3 bits)
//   din  : write data (32 bits)
//   dout : combinational read data (32 bits)
// The master modport is the CPU side and the slave modport is the decoder side.
`timescale 1ns/1ps
interface quadrature_decoder_if;
  logic        rden;
  logic        wren;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output rden, output wren, output addr, output din, input dout);
  modport slave  (input rden, input wren, input addr, input din, output dout);
endinterface

// File: rtl/quadrature_decoder.sv
// quadrature_decoder
// Decodes the raw A/B encoder channels into a signed 32-bit position and a
// one-cycle step/dir strobe pair. Both channels are synchronized and can
// optionally be glitch-filtered. Illegal transitions, where both bits change
// at once, set a sticky error flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   bus (slave)  register bus (rden, wren, addr, din, dout)
//   enc_a, enc_b raw encoder channels, asynchronous to clk
//   step         one-cycle pulse per decoded quadrature edge
//   dir          direction of the last step (1 = forward, 0 = reverse)
//
// Registers:
//   0 position (RW)
//   1 control/status
//       bit0 enable       (RW)
//       bit1 dir          (RO)
//       bit2 error        (sticky, write-1-to-clear)
//       bit3 synced A     (RO)
//       bit4 synced B     (RO)
//   2 filter length[3:0] (only with QUAD_GLITCH_FILTER_EN)
//
// Optional feature macro: QUAD_GLITCH_FILTER_EN. When it is defined, the
// debounced state only follows the synchronized input after the input has
// differed from it for N consecutive cycles, where N is the filter length.
`timescale 1ns/1ps
module quadrature_decoder (
  input  logic                 clk,
  input  logic                 reset,
  quadrature_decoder_if.slave  bus,
  input  logic                 enc_a,
  input  logic                 enc_b,
  output logic                 step,
  output logic                 dir
);

  localparam logic [2:0] ADDR_POS    = 3'b000;
  localparam logic [2:0] ADDR_CTRL   = 3'b001;
  localparam logic [2:0] ADDR_FILTER = 3'b010;

  // Position of a {B,A} code in the forward Gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  ab_f_q, ab_f_d;
  logic [1:0]  ab_prev_q, ab_prev_d;
  logic [1:0]  startup_q, startup_d;
  logic [31:0] pos_q, pos_d;
  logic        en_q, en_d;
  logic        err_q, err_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;

  logic        active;
  logic [1:0]  idx_diff;
  logic        fwd, rev, illegal;
  logic        wr_pos, wr_ctrl;

`ifdef QUAD_GLITCH_FILTER_EN
  logic [3:0]  filt_q, filt_d;
  logic [3:0]  run_q, run_d;
  logic [3:0]  run_inc;
  logic [3:0]  n_eff;
  logic [1:0]  cand_q, cand_d;
  logic        wr_filt;
`endif

  // ---- stage: synchronizer (s1 -> s2) ----
  always_comb begin
    sync1_d = {enc_b, enc_a};
    sync2_d = sync1_q;
  end

  // ---- stage: debounced state ab_f ----
  // While the startup window is open, ab_f loads straight from s2 and the
  // previous-state register follows it too. This way an encoder resting at
  // a non-zero code is absorbed without being decoded as a transition.
  assign active = (startup_q == 2'd0);

`ifdef QUAD_GLITCH_FILTER_EN
  assign n_eff   = (filt_q == 4'd0) ? 4'd1 : filt_q;
  assign wr_filt = bus.wren && (bus.addr == ADDR_FILTER);

  always_comb begin
    ab_f_d  = ab_f_q;
    run_d   = 4'd0;
    run_inc = 4'd0;
    cand_d  = sync2_q;
    filt_d  = wr_filt ? bus.din[3:0] : filt_q;
    if (!active) begin
      ab_f_d = sync2_q;
    end else if (sync2_q != ab_f_q) begin
      // A new differing value starts a fresh run. A run only grows while
      // s2 holds the same value.
      run_inc = (sync2_q != cand_q) ? 4'd1 : run_q + 4'd1;
      if (run_inc >= n_eff) begin
        ab_f_d = sync2_q;
      end else begin
        run_d = run_inc;
      end
    end
  end
`else
  always_comb begin
    ab_f_d = sync2_q;
  end
`endif

  // ---- stage: decode and register update ----
  always_comb begin
    idx_diff = gray_idx(ab_f_q) - gray_idx(ab_prev_q);
    fwd      = active && (idx_diff == 2'd1);
    rev      = active && (idx_diff == 2'd3);
    illegal  = active && (idx_diff == 2'd2);
    wr_pos   = bus.wren && (bus.addr == ADDR_POS);
    wr_ctrl  = bus.wren && (bus.addr == ADDR_CTRL);

    ab_prev_d = active ? ab_f_q : ab_f_d;
    startup_d = active ? startup_q : startup_q - 2'd1;

    pos_d  = pos_q;
    en_d   = en_q;
    err_d  = err_q;
    step_d = 1'b0;
    dir_d  = dir_q;

    if (en_q && (fwd || rev)) begin
      step_d = 1'b1;
      dir_d  = fwd;
      pos_d  = fwd ? pos_q + 32'd1 : pos_q - 32'd1;
    end
    // A CPU write to the position overrides a step in the same cycle.
    if (wr_pos) begin
      pos_d = bus.din;
    end
    if (wr_ctrl) begin
      en_d = bus.din[0];
      if (bus.din[2]) begin
        err_d = 1'b0;
      end
    end
    // A newly detected error takes priority over a clear in the same cycle.
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      ab_f_q    <= 2'b00;
      ab_prev_q <= 2'b00;
      startup_q <= 2'd3;
      pos_q     <= 32'd0;
      en_q      <= 1'b1;
      err_q     <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ab_f_q    <= ab_f_d;
      ab_prev_q <= ab_prev_d;
      startup_q <= startup_d;
      pos_q     <= pos_d;
      en_q      <= en_d;
      err_q     <= err_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 4'd4;
      run_q  <= 4'd0;
      cand_q <= 2'b00;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
      cand_q <= cand_d;
    end
  end
`endif

  assign step = step_q;
  assign dir  = dir_q;

  // ---- read mux ----
  always_comb begin
    bus.dout = 32'd0;
    if (bus.rden) begin
      case (bus.addr)
        ADDR_POS:    bus.dout = pos_q;
        ADDR_CTRL:   bus.dout = {27'd0, sync2_q[1], sync2_q[0], err_q, dir_q, en_q};
`ifdef QUAD_GLITCH_FILTER_EN
        ADDR_FILTER: bus.dout = {28'd0, filt_q};
`endif
        default:     bus.dout = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Front end of the motor-position path. Decodes the raw A/B quadrature signals from a motor encoder into a signed 32-bit position and a one-cycle `step`/`dir` strobe pair; the strobe pair drives the edge-counting stage downstream. Both encoder inputs are synchronized and optionally glitch-filtered. Illegal A/B transitions are flagged. A lab-7-style register bus lets the embedded microcontroller read and write the position, enable, error and filter registers.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- rden  in  1  read enable; `dout` is 0 when low.
- wren  in  1  write strobe; writes the register at `addr` on the rising edge.
- addr  in  3  register address.
- din  in  32  write data.
- dout  out  32  read data (combinational from `addr`/`rden`); reset 0.
- enc_a  in  1  encoder channel A, asynchronous to `clk`.
- enc_b  in  1  encoder channel B, asynchronous to `clk`.
- step  out  1  one-cycle pulse per decoded quadrature edge; reset 0.
- dir  out  1  direction of the last step: 1 = forward, 0 = reverse; reset 0.

## Operation
- Sync: `enc_a` and `enc_b` each pass through a 2-flop synchronizer (s1 → s2). The resulting 2-bit value is {B,A}.
- Filtered state `ab_f`: the debounced {B,A} value the decoder works from (see Configuration for how it is updated).
- Decode: compare the new `ab_f` with the previous `ab_f`.
  - Forward sequence: 00→01→11→10→00.
  - Reverse sequence: the opposite order.
  - Forward: position +1, `dir`=1. Reverse: position −1, `dir`=0.
  - No change: nothing happens.
  - Both bits change (00↔11 or 01↔10): illegal. Sets the sticky error bit; no step, position unchanged, `dir` unchanged.
- Enable = 0:
  - Position frozen, `step` held at 0, `dir` unchanged.
  - `ab_f` tracking and error detection continue.
- Startup: for 3 cycles after reset deasserts, `ab_f` loads directly from s2 and decoding is suppressed. An encoder resting at 11 therefore never produces a false error.
- Arithmetic: position is modulo 2^32. 0xFFFFFFFF +1 → 0; 0 −1 → 0xFFFFFFFF.
- Registers (unlisted addresses read 0 and ignore writes):
  - 0b000 position: RW, reset 0.
  - 0b001 control/status:
    - bit0 enable: RW, reset 1.
    - bit1 dir: RO.
    - bit2 error: sticky, write-1-to-clear, reset 0.
    - bit3 synced A: RO.
    - bit4 synced B: RO.
    - other bits: read 0.
  - 0b010 filter length: bits[3:0], reset 4; see Configuration.
- Simultaneous events:
  - CPU write to position and a decoded step in the same cycle: the write wins; position = `din`, but `step`/`dir` still pulse normally.
  - Error set and write-1-to-clear in the same cycle: set wins.
- Reset mid-operation: all state returns to its reset values immediately (asynchronous), and the startup window restarts.

## Timing
- Latency, filter compiled out: an input change that is stable before rising edge E1 updates s1 at E1, s2 at E2, `ab_f` at E3, and position/`step`/`dir` at E4.
- Latency, filter compiled in with length N: 3+N edges (N=1 equals the no-filter latency).
- `step` is high for exactly one cycle per decoded edge. Consecutive edges may produce back-to-back pulses.
- Register writes take effect on the `wren` edge. Reads reflect the updated value in the next cycle.

## Configuration
- Macro `QUAD_GLITCH_FILTER_EN`.
- Defined:
  - `ab_f` takes s2 only after s2 has differed from `ab_f` for N consecutive cycles, where N = filter register (N=0 is treated as 1).
  - Pulses shorter than N cycles are ignored.
  - The in-progress run counter resets whenever s2 returns to `ab_f` or changes value.
- Undefined:
  - `ab_f` <= s2 every cycle.
  - Address 0b010 reads 0 and ignores writes.

## Test plan
- Reset, then drive forward sequence 00→01→11→10→00 with 10-cycle spacing → four `step` pulses with `dir`=1; position reads 4; error bit 0.
- Position preset to 0, then one reverse edge → position 0xFFFFFFFF, `dir`=0. Then write 0x7FFFFFFF to position and drive one forward edge → position 0x80000000.
- Drive A and B simultaneously 00→11 → no `step`, position unchanged, status bit2=1. Write 0x5 to status → error cleared, enable still 1.
- Clear enable, then drive 3 forward edges → position unchanged, no `step`. Re-enable, then drive 1 forward edge → position +1 with no spurious count.
- With `QUAD_GLITCH_FILTER_EN` and N=4: a 3-cycle glitch on A → no step, no error. A 6-cycle level change on A → exactly one step, at 7 cycles after the input change.
- Hold encoder at 11 through reset release → no error, no step. Assert reset mid-sequence → all outputs and registers return to their reset values.
